regmux_nto1_rr: RTL and testbench

//  Registered N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.

---
 rtl/regmux_nto1_rr_pkg.sv | 18 +
 rtl/regmux_nto1_rr_slice.sv | 23 ++
 rtl/regmux_nto1_rr.sv | 96 +++++++++
 tb/tb_regmux_nto1_rr.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/regmux_nto1_rr_pkg.sv
// Shared definitions for the registered N:1 mux: arbitration mode encodings
// and a constant-foldable ceil(log2) helper for deriving select widths.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Returns at least 1 so a 1-channel build still has a legal select width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regmux_nto1_rr_slice.sv
// Combinational SLICE-bit N:1 multiplexer; channel c occupies din[c*SLICE +: SLICE].
module slice_mux_nto1
  import mux_pkg::*;
#(
  parameter  int SLICE = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = clog2(NCH)
) (
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*SLICE-1:0] din,
  output logic [SLICE-1:0]     dout
);

  // NOTE: dout gets a default before the loop so every path assigns it and
  // no latch is inferred for out-of-range select values.
  always_comb begin
    dout = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel == SELW'(c)) dout = din[c*SLICE +: SLICE];
    end
  end

endmodule

// File: rtl/regmux_nto1_rr.sv
// Registered N-channel mux with valid/ready on every port and selectable
// arbitration (explicit select or round-robin); one cycle of latency.
module regmux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  parameter  int SLICE = 8,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  localparam int NSLICE = WIDTH / SLICE;

  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] rr_ptr;
  logic            can_load;
  logic            accept;
  logic [WIDTH-1:0] mux_data;

  always_comb begin
    int c;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    if (mode == MODE_SEL) begin
      // Scanning real channel ids means sel >= NCH can never match.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int off = 1; off <= NCH; off++) begin
        c = (int'(rr_ptr) + off) % NCH;
        if (!grant_vld && in_valid[c]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(c);
        end
      end
    end
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign can_load = rst_n & (~out_valid | out_ready);
  assign accept   = can_load & grant_vld;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    logic [NCH*SLICE-1:0] slice_in;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign slice_in[c*SLICE +: SLICE] = in_data[c*WIDTH + g*SLICE +: SLICE];
    end
    slice_mux_nto1 #(.SLICE(SLICE), .NCH(NCH)) u_mux (
      .sel  (grant_idx),
      .din  (slice_in),
      .dout (mux_data[g*SLICE +: SLICE])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesised netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(NCH - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_ch    <= grant_idx;
      if (mode == MODE_RR) rr_ptr <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regmux_nto1_rr.sv
// Directed bench for regmux_nto1_rr (WIDTH=32, NCH=4, SLICE=8) with
// hand-computed expectations for grant, handshake and register behaviour.
module tb_regmux_nto1_rr;
  import mux_pkg::*;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;

  logic [WIDTH-1:0] chd [NCH];

  int checks   = 0;
  int failures = 0;

  assign in_data = {chd[3], chd[2], chd[1], chd[0]};

  regmux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch;
    rst_n     = 1'b0;
    mode      = MODE_RR;
    sel       = '0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) chd[c] = 32'hC0DE_0000 | c;

    // 1. Reset state, then the first RR search starts at ch0.
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    tick();
    check("rr_first_ch", 32'(out_ch), 32'd0);
    check("rr_first_data", out_data, 32'hC0DE_0000);
    check("rr_first_valid", 32'(out_valid), 32'd1);

    // 2. Explicit select of ch2.
    mode = MODE_SEL; sel = 2'd2; in_valid = 4'b0100; chd[2] = 32'hDEADBEEF;
    #1;
    check("sel2_ready", 32'(in_ready), 32'b0100);
    tick();
    check("sel2_data", out_data, 32'hDEADBEEF);
    check("sel2_ch", 32'(out_ch), 32'd2);

    // 3. Park rr_ptr on ch3 (only ch3 valid), then full round-robin rotation.
    chd[2] = 32'hC0DE_0002;
    mode = MODE_RR; in_valid = 4'b1000;
    tick();
    check("rr_park_ch", 32'(out_ch), 32'd3);
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      exp_ch = i % NCH;
      #1;
      check($sformatf("rr_rot_ready%0d", i), 32'(in_ready), 32'(1 << exp_ch));
      tick();
      check($sformatf("rr_rot_ch%0d", i), 32'(out_ch), 32'(exp_ch));
      check($sformatf("rr_rot_data%0d", i), out_data, 32'hC0DE_0000 | 32'(exp_ch));
    end

    // 4. Back-pressure holds the register; release drains and loads together.
    mode = MODE_SEL; sel = 2'd0; in_valid = 4'b0001; chd[0] = 32'hA5A5A5A5;
    tick();
    check("bp_fill_data", out_data, 32'hA5A5A5A5);
    out_ready = 1'b0; chd[0] = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("bp_data%0d", i), out_data, 32'hA5A5A5A5);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    tick();
    check("bp_release_data", out_data, 32'h12345678);
    check("bp_release_valid", 32'(out_valid), 32'd1);

    // 5. rr_ptr still 3 after SEL accepts: ch0 moves it to 0, then 3 and wrap to 0.
    mode = MODE_RR; in_valid = 4'b0001; chd[0] = 32'hC0DE_0000;
    tick();
    check("wrap_setup_ch", 32'(out_ch), 32'd0);
    in_valid = 4'b1001;
    #1;
    check("wrap_ready_ch3", 32'(in_ready), 32'b1000);
    tick();
    check("wrap_ch3", 32'(out_ch), 32'd3);
    #1;
    check("wrap_ready_ch0", 32'(in_ready), 32'b0001);
    tick();
    check("wrap_ch0", 32'(out_ch), 32'd0);
    mode = MODE_SEL; sel = 2'd1; in_valid = 4'b0001;
    #1;
    check("nogrant_ready", 32'(in_ready), 32'h0);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_ch", 32'(out_ch), 32'd0);
    check("drain_hold_data", out_data, 32'hC0DE_0000);

    // 6. Asynchronous reset while FULL clears outputs before any clock edge.
    sel = 2'd0; chd[0] = 32'h0BAD_F00D;
    tick();
    check("arst_fill_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0; in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", out_data, 32'h0);
    check("arst_ready", 32'(in_ready), 32'h0);
    tick();
    check("arst_held_ready", 32'(in_ready), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
